// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one block-wide data memory between the icache (read port I)
//          and the dcache (read/write port D), serialising whole block transfers.
// Latency: one cycle IDLE->GRANT, then memory busy time + 1 to DONE; one idle
//          cycle between transfers. Busywait stalls each requester until its
//          DONE cycle.
// Option:  define ARB_ROUND_ROBIN_EN to alternate ownership on ties (default:
//          D always wins a tie).
module mem_bus_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    // icache port (read only)
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    // dcache port (read / write-back)
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    // data memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    state_t              state_q;
    owner_t              owner_q;
    logic                seen_busy_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic [DATA_W-1:0]   mem_writedata_q;
    logic [DATA_W-1:0]   i_readdata_q;
    logic [DATA_W-1:0]   d_readdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = I served last, 1 = D served last
    logic                last_owner_q;
`endif

    logic                i_req;
    logic                d_req;
    logic                pick_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Arbitration decision used only while IDLE: does D get the next grant?
    always_comb begin
        pick_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        // On a tie the port that was not served last wins
        pick_d = d_req & (~i_req | ~last_owner_q);
`else
        pick_d = d_req;
`endif
    end

    // Arbiter FSM: latches the winner's command at grant, waits for the
    // memory busy pulse to complete, returns read data and releases.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            owner_q         <= OWN_NONE;
            seen_busy_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            i_readdata_q    <= '0;
            d_readdata_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    seen_busy_q <= 1'b0;
                    if (pick_d) begin
                        state_q       <= GRANT_D;
                        owner_q       <= OWN_D;
                        mem_address_q <= d_address;
                        // a simultaneous read+write is a write-back
                        mem_read_q    <= d_read & ~d_write;
                        mem_write_q   <= d_write;
                        if (d_write) begin
                            mem_writedata_q <= d_writedata;
                        end
                    end else if (i_req) begin
                        state_q       <= GRANT_I;
                        owner_q       <= OWN_I;
                        mem_address_q <= i_address;
                        mem_read_q    <= 1'b1;
                        mem_write_q   <= 1'b0;
                    end
                end

                GRANT_I, GRANT_D: begin
                    // Completion needs a busy pulse first, so a stale low
                    // busywait at grant time is not mistaken for done.
                    if (mem_busywait) begin
                        seen_busy_q <= 1'b1;
                    end else if (seen_busy_q) begin
                        seen_busy_q <= 1'b0;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (owner_q == OWN_I) begin
                            i_readdata_q <= mem_readdata;
                            state_q      <= DONE_I;
`ifdef ARB_ROUND_ROBIN_EN
                            last_owner_q <= 1'b0;
`endif
                        end else begin
                            if (mem_read_q) begin
                                d_readdata_q <= mem_readdata;
                            end
                            state_q      <= DONE_D;
`ifdef ARB_ROUND_ROBIN_EN
                            last_owner_q <= 1'b1;
`endif
                        end
                    end
                end

                DONE_I, DONE_D: begin
                    // single release cycle, then re-arbitrate from IDLE
                    state_q <= IDLE;
                    owner_q <= OWN_NONE;
                end

                default: begin
                    state_q <= IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign i_readdata    = i_readdata_q;
    assign d_readdata    = d_readdata_q;

    // Each requester is stalled except during its own DONE cycle
    assign i_busywait = i_req & (state_q != DONE_I);
    assign d_busywait = d_req & (state_q != DONE_D);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table for arbitration and grant
// latching from IDLE, plus hand sequences for full transfers, contention,
// mid-grant input change and reset during a transfer.
module tb_mem_bus_arbiter;

    logic        CLK;
    logic        RESET;
    logic        i_read;
    logic [5:0]  i_address;
    logic [31:0] i_readdata;
    logic        i_busywait;
    logic        d_read;
    logic        d_write;
    logic [5:0]  d_address;
    logic [31:0] d_writedata;
    logic [31:0] d_readdata;
    logic        d_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int checks;
    int failures;

    mem_bus_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: one cycle after a strobe it goes busy for 4 cycles, then
    // completes and waits for the strobes to drop before accepting again.
    int          mstate;
    int          mcnt;
    logic [5:0]  wr_addr_seen;
    logic [31:0] wr_data_seen;

    function automatic logic [31:0] rd_pat(input logic [5:0] a);
        case (a)
            6'h05:   rd_pat = 32'hDEADBEEF;
            6'h01:   rd_pat = 32'h11111111;
            6'h10:   rd_pat = 32'h22222222;
            default: rd_pat = 32'hA5A50000 | {26'b0, a};
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            mstate       <= 0;
            mcnt         <= 0;
            mem_busywait <= 1'b0;
            mem_readdata <= 32'h0;
            wr_addr_seen <= 6'h0;
            wr_data_seen <= 32'h0;
        end else begin
            case (mstate)
                0: if (mem_read || mem_write) begin
                    mstate       <= 1;
                    mem_busywait <= 1'b1;
                    mcnt         <= 3;
                end
                1: if (mcnt == 0) begin
                    mem_busywait <= 1'b0;
                    mstate       <= 2;
                    if (mem_read)  mem_readdata <= rd_pat(mem_address);
                    if (mem_write) begin
                        wr_addr_seen <= mem_address;
                        wr_data_seen <= mem_writedata;
                    end
                end else begin
                    mcnt <= mcnt - 1;
                end
                default: if (!mem_read && !mem_write) mstate <= 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Wait for the given port's DONE cycle; counts address instability and
    // (optionally) the other port unexpectedly released. Timeout adds 1000.
    task automatic xfer_wait(input bit port_d, input logic [5:0] exp_addr,
                             input bit other_busy, output int viol);
        viol = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge CLK);
            if ((port_d ? d_busywait : i_busywait) == 1'b0) return;
            if ((mem_read || mem_write) && mem_address !== exp_addr) viol++;
            if (other_busy && (port_d ? i_busywait : d_busywait) !== 1'b1) viol++;
        end
        viol += 1000;
    endtask

    task automatic clear_inputs();
        i_read = 0; i_address = 0;
        d_read = 0; d_write = 0; d_address = 0; d_writedata = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        clear_inputs();
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    typedef struct {
        logic        ir, dr, dw;
        logic [5:0]  ia, da;
        logic [31:0] wd;
        logic        ibw, dbw, mr, mw;
        logic [5:0]  ma;
        logic [31:0] mwd;
    } vec_t;

    vec_t tv[7];
    int   viol;
    bit   got_d;
    bit   exp_d;
    bit   seen;

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b1;
        clear_inputs();

        //        ir dr dw ia     da     wd            ibw dbw mr mw ma     mwd
        tv[0] = '{0, 0, 0, 6'h00, 6'h00, 32'h0,        0,  0,  0, 0, 6'h00, 32'h0};
        tv[1] = '{1, 0, 0, 6'h05, 6'h00, 32'h0,        1,  0,  1, 0, 6'h05, 32'h0};
        tv[2] = '{0, 1, 0, 6'h00, 6'h10, 32'h0,        0,  1,  1, 0, 6'h10, 32'h0};
        tv[3] = '{0, 0, 1, 6'h00, 6'h2A, 32'h01020304, 0,  1,  0, 1, 6'h2A, 32'h01020304};
        tv[4] = '{0, 1, 1, 6'h00, 6'h11, 32'hAABBCCDD, 0,  1,  0, 1, 6'h11, 32'hAABBCCDD};
        tv[5] = '{1, 1, 0, 6'h01, 6'h10, 32'h0,        1,  1,  1, 0, 6'h10, 32'h0};
        tv[6] = '{1, 0, 1, 6'h01, 6'h3F, 32'h55667788, 1,  1,  0, 1, 6'h3F, 32'h55667788};

        // reset state
        do_reset();
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_writedata", mem_writedata, 0);
        chk("rst_i_readdata", i_readdata, 0);
        chk("rst_d_readdata", d_readdata, 0);
        chk("rst_i_busywait", i_busywait, 0);
        chk("rst_d_busywait", d_busywait, 0);

        // vector table: busywait in IDLE, then latched command after one edge
        for (int k = 0; k < 7; k++) begin
            do_reset();
            i_read = tv[k].ir; d_read = tv[k].dr; d_write = tv[k].dw;
            i_address = tv[k].ia; d_address = tv[k].da; d_writedata = tv[k].wd;
            #1;
            chk($sformatf("v%0d_i_busywait", k), i_busywait, tv[k].ibw);
            chk($sformatf("v%0d_d_busywait", k), d_busywait, tv[k].dbw);
            @(negedge CLK);
            chk($sformatf("v%0d_mem_read", k), mem_read, tv[k].mr);
            chk($sformatf("v%0d_mem_write", k), mem_write, tv[k].mw);
            chk($sformatf("v%0d_mem_address", k), mem_address, tv[k].ma);
            chk($sformatf("v%0d_mem_writedata", k), mem_writedata, tv[k].mwd);
        end

        // reset held 2 cycles with a write pending, then D write transfer
        RESET = 1'b1;
        clear_inputs();
        d_write = 1; d_address = 6'h2A; d_writedata = 32'h01020304;
        @(negedge CLK);
        @(negedge CLK);
        chk("hold_rst_mem_read", mem_read, 0);
        chk("hold_rst_mem_write", mem_write, 0);
        chk("hold_rst_i_busywait", i_busywait, 0);
        chk("hold_rst_d_busywait", d_busywait, 1);
        RESET = 1'b0;
        @(negedge CLK);
        chk("dw_grant_mem_write", mem_write, 1);
        chk("dw_grant_mem_writedata", mem_writedata, 32'h01020304);
        xfer_wait(1'b1, 6'h2A, 1'b0, viol);
        chk("dw_hold", viol, 0);
        chk("dw_done_mem_write", mem_write, 0);
        chk("dw_d_readdata_unchanged", d_readdata, 0);
        chk("dw_mem_got_addr", wr_addr_seen, 6'h2A);
        chk("dw_mem_got_data", wr_data_seen, 32'h01020304);
        @(negedge CLK);
        chk("dw_release_one_cycle", d_busywait, 1);
        d_write = 0;

        // I read alone
        @(negedge CLK);
        i_read = 1; i_address = 6'h05;
        @(negedge CLK);
        chk("ir_grant_mem_read", mem_read, 1);
        chk("ir_grant_mem_address", mem_address, 6'h05);
        xfer_wait(1'b0, 6'h05, 1'b0, viol);
        chk("ir_hold", viol, 0);
        chk("ir_i_readdata", i_readdata, 32'hDEADBEEF);
        chk("ir_done_mem_read", mem_read, 0);
        @(negedge CLK);
        chk("ir_release_one_cycle", i_busywait, 1);
        i_read = 0;
        @(negedge CLK);
        chk("ir_idle_busywait", i_busywait, 0);
        chk("ir_idle_mem_read", mem_read, 0);

        // contention: D first, idle cycle, then I; I stalled throughout
        do_reset();
        i_read = 1; i_address = 6'h01;
        d_read = 1; d_address = 6'h10;
        xfer_wait(1'b1, 6'h10, 1'b1, viol);
        chk("ct_d_first", viol, 0);
        chk("ct_d_readdata", d_readdata, 32'h22222222);
        d_read = 0;
        @(negedge CLK);
        chk("ct_idle_mem_read", mem_read, 0);
        chk("ct_idle_i_busywait", i_busywait, 1);
        xfer_wait(1'b0, 6'h01, 1'b0, viol);
        chk("ct_i_second", viol, 0);
        chk("ct_i_readdata", i_readdata, 32'h11111111);
        i_read = 0;
        @(negedge CLK);

        // repeated contention: fixed priority D,D,.. / round robin D,I,D,I
        do_reset();
        i_read = 1; i_address = 6'h01;
        d_read = 1; d_address = 6'h10;
        for (int k = 0; k < 4; k++) begin
            seen  = 1'b0;
            got_d = 1'b0;
            for (int n = 0; n < 60 && !seen; n++) begin
                @(negedge CLK);
                if (!d_busywait || !i_busywait) begin
                    seen  = 1'b1;
                    got_d = !d_busywait;
                end
            end
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            chk($sformatf("rr_grant%0d_seen", k), seen, 1);
            chk($sformatf("rr_grant%0d_is_d", k), got_d, exp_d);
            @(negedge CLK);
        end
        clear_inputs();
        @(negedge CLK);

        // requester changes address mid-grant: latched address holds
        do_reset();
        d_read = 1; d_address = 6'h10;
        @(negedge CLK);
        chk("chg_grant_addr", mem_address, 6'h10);
        @(negedge CLK);
        d_address = 6'h3F;
        xfer_wait(1'b1, 6'h10, 1'b0, viol);
        chk("chg_addr_held", viol, 0);
        chk("chg_d_readdata", d_readdata, 32'h22222222);
        d_read = 0;
        @(negedge CLK);

        // reset while memory is busy: strobes drop, no release, then re-grant
        do_reset();
        d_read = 1; d_address = 6'h10;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge CLK);
            if (mem_busywait) seen = 1'b1;
        end
        chk("mid_rst_mem_busy_seen", seen, 1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("mid_rst_mem_read", mem_read, 0);
        chk("mid_rst_mem_write", mem_write, 0);
        viol = 0;
        for (int n = 0; n < 3; n++) begin
            if (d_busywait !== 1'b1) viol++;
            @(negedge CLK);
        end
        chk("mid_rst_busy_held", viol, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("mid_rst_regrant", mem_read, 1);
        xfer_wait(1'b1, 6'h10, 1'b0, viol);
        chk("mid_rst_finish", viol, 0);
        chk("mid_rst_d_readdata", d_readdata, 32'h22222222);
        d_read = 0;
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
